// File: rtl/bcd_to_binary_converter_pkg.sv
// Shared constants and state encoding for the BCD-to-binary converter.
// Optional build macro: RANGE_CHECK_EN (rejects non-decimal digits at acceptance).
package bcd_pkg;

    localparam int DEF_DIGITS = 3;
    localparam int DEF_BIN_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Reverse double-dabble nibble correction constants
    localparam logic [3:0] NIB_THRESH = 4'd8;
    localparam logic [3:0] NIB_CORR   = 4'd3;
    localparam logic [3:0] NIB_MAX    = 4'd9;

endpackage

// File: rtl/bcd_to_binary_converter_if.sv
// Handshake bundle between a producer of packed BCD values and the converter.
// The converter uses the slave modport; the feeding/consuming side uses master.
interface bcd_to_binary_converter_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [BIN_W-1:0]      bin_out;
    logic                  out_err;
    logic                  busy;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, bin_out, out_err, busy
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, bin_out, out_err, busy
    );

endinterface

// File: rtl/bcd_to_binary_converter_nibble_adjust.sv
// One BCD nibble correction step of the reverse double-dabble:
// a nibble that reads 8 or more after the right shift gets 3 removed.
module bcd_nibble_adjust
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    // Correction only fires at >= 8, so the subtraction can never wrap
    assign nib_o = (nib_i >= NIB_THRESH) ? (nib_i - NIB_CORR) : nib_i;

endmodule

// File: rtl/bcd_to_binary_converter.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per
// clock). Result is ready BIN_W cycles after acceptance and held until taken.
// Optional build macro: RANGE_CHECK_EN -- digits above 9 short-circuit to an
// error result (bin_out=0, out_err=1) one cycle after acceptance.
module bcd_to_binary_converter
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
)(
    input  logic                          clk,
    input  logic                          reset,
    bcd_to_binary_converter_if.slave      bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    state_e              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0]    bin_q, bin_d;

    logic [WORK_W-1:0]   shifted;
    logic [BCD_W-1:0]    adj_bcd;
    logic [WORK_W-1:0]   stepped;

    // Shift the whole {bcd, bin} register; bcd bits migrate into the binary field
    assign shifted = work_q >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adjust u_adj (
            .nib_i (shifted[BIN_W + 4*g +: 4]),
            .nib_o (adj_bcd[4*g +: 4])
        );
    end

    assign stepped = {adj_bcd, shifted[BIN_W-1:0]};

`ifdef RANGE_CHECK_EN
    logic err_q, err_d;
    logic bad_digit;

    // Flag any input nibble that is not a decimal digit
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > NIB_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end
`endif

    // Next-state, work register, counter and result selection
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
`ifdef RANGE_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    work_d  = {bus.bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef RANGE_CHECK_EN
                    err_d   = bad_digit;
                    if (bad_digit) begin
                        bin_d   = '0;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_SHIFT: begin
                work_d = stepped;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    bin_d   = stepped[BIN_W-1:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result held until the consumer takes it; no accept this edge
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
`ifdef RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
`ifdef RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_SHIFT);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.bin_out   = bin_q;
`ifdef RANGE_CHECK_EN
    assign bus.out_err   = err_q;
`else
    assign bus.out_err   = 1'b0;
`endif

endmodule
